// File: rtl/x_rams_nxw.sv
// x_rams_nxw: single-port distributed RAM, DEPTH x WIDTH, asynchronous read,
// synchronous write, optional registered output and a built-in clear sequencer
// that fills the array with INIT_WORD after reset or on request.
module x_rams_nxw #(
  parameter int unsigned       WIDTH          = 1,
  parameter int unsigned       DEPTH          = 32,
  parameter int unsigned       ADDR_W         = 5,
  parameter logic [WIDTH-1:0]  INIT_WORD      = '0,
  parameter int unsigned       OUT_REG        = 0,
  parameter int unsigned       CLEAR_ON_RESET = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] ADR,
  input  logic [WIDTH-1:0]  I,
  input  logic              WE,
  input  logic              CE,
  input  logic              CLR,
  output logic              BUSY,
  output logic [WIDTH-1:0]  O
);

  // Reject geometries the array cannot represent.
  generate
    if ((DEPTH > (64'd1 << ADDR_W)) || (DEPTH < 2) || (WIDTH < 1)) begin : g_bad_param
      $error("x_rams_nxw: illegal parameters (need 2 <= DEPTH <= 2**ADDR_W, WIDTH >= 1)");
    end
  endgenerate

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  localparam state_t            RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADR  = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              in_range;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  rd_data;

  // Addresses at or beyond DEPTH neither write nor read the array.
  assign in_range = ({1'b0, ADR} < DEPTH_W);
  assign rd_data  = in_range ? mem[ADR] : '0;
  assign BUSY     = (state_q == S_CLEAR);

  // Sequencer state and clear counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and the single write port: the sequencer owns it while clearing,
  // otherwise the user port writes unless a clear request takes this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = ADR;
    wr_data = I;
    unique case (state_q)
      S_IDLE: begin
        if (CLR) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (WE && in_range) begin
          wr_en = 1'b1;
        end
      end
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = INIT_WORD;
        if (cnt_q == LAST_ADR) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // No array writes while reset is held; the sequence restarts cleanly on release.
    if (!RST_N) begin
      wr_en = 1'b0;
    end
  end

  // Array write; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] o_q;

      // Registered read, read-first against a same-edge write; CE=0 holds.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          o_q <= '0;
        end else if (CE) begin
          o_q <= rd_data;
        end
      end

      assign O = o_q;
    end else begin : g_out_comb
      logic unused_ce;
      assign unused_ce = CE;
      assign O         = rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_x_rams_nxw.sv
// tb_x_rams_nxw: self-checking bench for x_rams_nxw. Four instances cover the
// combinational and registered read paths, a non-power-of-2 depth and a
// 1-bit-wide array compared against a behavioural reference array.
module tb_x_rams_nxw;

  logic       clk;
  logic       rst_n;
  logic [4:0] adr;
  logic [7:0] din;
  logic       we, ce, clr;
  logic [7:0] o_a, o_b, o_c;
  logic       busy_a, busy_b, busy_c;

  logic [4:0] adr_d;
  logic [0:0] din_d;
  logic       we_d, ce_d, clr_d;
  logic [0:0] o_d;
  logic       busy_d;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ref_c [24];
  logic [0:0] ref_d [32];

  x_rams_nxw #(.WIDTH(8), .DEPTH(32), .ADDR_W(5), .INIT_WORD(8'hA5),
               .OUT_REG(0), .CLEAR_ON_RESET(1)) u_a (
    .CLK(clk), .RST_N(rst_n), .ADR(adr), .I(din), .WE(we), .CE(ce),
    .CLR(clr), .BUSY(busy_a), .O(o_a));

  x_rams_nxw #(.WIDTH(8), .DEPTH(32), .ADDR_W(5), .INIT_WORD(8'hA5),
               .OUT_REG(1), .CLEAR_ON_RESET(1)) u_b (
    .CLK(clk), .RST_N(rst_n), .ADR(adr), .I(din), .WE(we), .CE(ce),
    .CLR(clr), .BUSY(busy_b), .O(o_b));

  x_rams_nxw #(.WIDTH(8), .DEPTH(24), .ADDR_W(5), .INIT_WORD(8'hA5),
               .OUT_REG(0), .CLEAR_ON_RESET(1)) u_c (
    .CLK(clk), .RST_N(rst_n), .ADR(adr), .I(din), .WE(we), .CE(ce),
    .CLR(clr), .BUSY(busy_c), .O(o_c));

  x_rams_nxw #(.WIDTH(1), .DEPTH(32), .ADDR_W(5), .INIT_WORD(1'b0),
               .OUT_REG(0), .CLEAR_ON_RESET(0)) u_d (
    .CLK(clk), .RST_N(rst_n), .ADR(adr_d), .I(din_d), .WE(we_d), .CE(ce_d),
    .CLR(clr_d), .BUSY(busy_d), .O(o_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until each clearing instance drops BUSY (0 if it never does).
  task automatic count_busy(output int n_a, output int n_c);
    n_a = 0;
    n_c = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (!busy_a && n_a == 0) n_a = k;
      if (!busy_c && n_c == 0) n_c = k;
      if (n_a != 0 && n_c != 0) break;
    end
  endtask

  task automatic check_all_a(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 32; i++) begin
      adr = 5'(i);
      @(negedge clk);
      check(tag, o_a, exp);
    end
  endtask

  initial begin
    int n_a, n_c;
    logic [4:0] a_sv;
    logic [0:0] d_sv;
    logic       w_sv;

    rst_n = 1'b1;
    adr = '0; din = '0; we = 1'b0; ce = 1'b0; clr = 1'b0;
    adr_d = '0; din_d = '0; we_d = 1'b0; ce_d = 1'b0; clr_d = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check("rst_busy_a", busy_a, 1);
    check("rst_busy_b", busy_b, 1);
    check("rst_busy_d", busy_d, 0);
    check("rst_oreg_b", o_b, 0);

    // Power-up clear: DEPTH cycles of BUSY, then all words read INIT_WORD.
    rst_n = 1'b1;
    count_busy(n_a, n_c);
    check("clr_len_a", n_a, 32);
    check("clr_len_c", n_c, 24);
    check("busy_d_idle", busy_d, 0);
    check_all_a("init_a", 8'hA5);
    for (int i = 0; i < 24; i++) ref_c[i] = 8'hA5;

    // Write visibility: combinational immediately, registered one edge later.
    adr = 5'd5; ce = 1'b1;
    tick();
    we = 1'b1; din = 8'h3C;
    tick();
    ref_c[5] = 8'h3C;
    we = 1'b0;
    check("wr_comb", o_a, 8'h3C);
    check("wr_reg_old", o_b, 8'hA5);
    tick();
    check("wr_reg_new", o_b, 8'h3C);
    ce = 1'b0; adr = 5'd6;
    tick();
    check("ce_hold", o_b, 8'h3C);
    @(negedge clk);
    check("rd_adr6", o_a, 8'hA5);

    // Out-of-range address on the 24-deep instance.
    adr = 5'd27; din = 8'hFF; we = 1'b1;
    tick();
    we = 1'b0;
    @(negedge clk);
    check("oor_read_c", o_c, 0);
    check("oor_write_a", o_a, 8'hFF);
    for (int i = 0; i < 24; i++) begin
      adr = 5'(i);
      @(negedge clk);
      check("oor_noalias_c", o_c, ref_c[i]);
    end

    // CLR and WE on the same edge: the write is dropped, then WE is ignored while busy.
    adr = 5'd3; din = 8'h11; we = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy_a", busy_a, 1);
    check("clr_busy_c", busy_c, 1);
    n_a = 0; n_c = 0;
    for (int k = 1; k <= 100; k++) begin
      if (k <= 20) begin
        we  = 1'($urandom);
        adr = 5'($urandom_range(0, 23));
        din = 8'($urandom);
      end else begin
        we = 1'b0;
      end
      tick();
      if (!busy_a && n_a == 0) n_a = k;
      if (!busy_c && n_c == 0) n_c = k;
      if (n_a != 0 && n_c != 0) break;
    end
    we = 1'b0;
    check("req_len_a", n_a, 32);
    check("req_len_c", n_c, 24);
    check_all_a("req_fill_a", 8'hA5);
    for (int i = 0; i < 24; i++) begin
      adr = 5'(i);
      @(negedge clk);
      check("req_fill_c", o_c, 8'hA5);
    end

    // Reset mid-clear: partial clear survives, sequence restarts from address 0.
    we = 1'b1;
    for (int i = 0; i < 32; i++) begin
      adr = 5'(i); din = 8'(i);
      tick();
    end
    we = 1'b0; ce = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy_a", busy_a, 1);
    check("midrst_busy_d", busy_d, 0);
    check("midrst_oreg_b", o_b, 0);
    adr = 5'd10;
    @(negedge clk);
    check("midrst_uncleared", o_a, 8'd10);
    adr = 5'd9;
    @(negedge clk);
    check("midrst_cleared", o_a, 8'hA5);
    tick();
    check("midrst_oreg_hold", o_b, 0);
    adr = 5'd12;
    rst_n = 1'b1;
    n_a = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 5) begin
        @(negedge clk);
        check("restart_from_0", o_a, 8'd12);
      end
      if (!busy_a) begin
        n_a = k;
        break;
      end
    end
    ce = 1'b0;
    check("restart_len_a", n_a, 32);
    check_all_a("restart_fill_a", 8'hA5);

    // 1-bit wide, no auto clear: random traffic against a reference array.
    we_d = 1'b1;
    for (int i = 0; i < 32; i++) begin
      adr_d = 5'(i); din_d = 1'($urandom);
      ref_d[i] = din_d;
      tick();
    end
    we_d = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      adr_d = 5'($urandom_range(0, 31));
      din_d = 1'($urandom);
      we_d  = 1'($urandom);
      a_sv = adr_d; d_sv = din_d; w_sv = we_d;
      @(negedge clk);
      check("rand_rd", o_d, ref_d[a_sv]);
      check("rand_busy", busy_d, 0);
      tick();
      if (w_sv) ref_d[a_sv] = d_sv;
      check("rand_rd_after_wr", o_d, ref_d[a_sv]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
